// File: rtl/data_memory_streamer_pkg.sv
// Shared definitions for the data memory burst initiator: memory command
// encodings, default geometry and the controller state type.
package data_memory_streamer_pkg;

  localparam int DEF_ADDR_LENGTH = 11;
  localparam int DEF_DATA_LENGTH = 16;

  localparam logic [1:0] WRRD_IDLE  = 2'b00;
  localparam logic [1:0] WRRD_READ  = 2'b01;
  localparam logic [1:0] WRRD_WRITE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_SEND  = 3'd2,
    S_WR_WAIT  = 3'd3,
    S_WR_ISSUE = 3'd4,
    S_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/data_memory_streamer.sv
// Burst initiator for the data memory port: DUMP streams memory words out,
// LOAD writes an incoming stream into consecutive memory addresses.
module data_memory_streamer
  import data_memory_streamer_pkg::*;
#(
  parameter int ADDR_LENGTH = DEF_ADDR_LENGTH,
  parameter int DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int CNT_LENGTH  = ADDR_LENGTH + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [ADDR_LENGTH-1:0] base_addr,
  input  logic [CNT_LENGTH-1:0]  count,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             mem_wrrd,
  output logic [ADDR_LENGTH-1:0] mem_addr,
  output logic [DATA_LENGTH-1:0] mem_wdata,
  input  logic [DATA_LENGTH-1:0] mem_rdata,
  output logic [DATA_LENGTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic [DATA_LENGTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready
);

  localparam logic [ADDR_LENGTH-1:0] ADDR_ONE  = {{(ADDR_LENGTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_LENGTH-1:0] ADDR_ZERO = {ADDR_LENGTH{1'b0}};
  localparam logic [CNT_LENGTH-1:0]  CNT_ONE   = {{(CNT_LENGTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_LENGTH-1:0]  CNT_ZERO  = {CNT_LENGTH{1'b0}};
  localparam logic [DATA_LENGTH-1:0] DATA_ZERO = {DATA_LENGTH{1'b0}};

  state_t                 state;
  state_t                 next_state;
  logic [ADDR_LENGTH-1:0] cur_addr;
  logic [ADDR_LENGTH-1:0] addr_next;
  logic [CNT_LENGTH-1:0]  remaining;
  logic                   last_word;
  logic                   count_zero;

  // Address wraps naturally at 2^ADDR_LENGTH; remaining is only decremented while >= 1.
  assign addr_next  = cur_addr + ADDR_ONE;
  assign last_word  = (remaining == CNT_ONE);
  assign count_zero = (count == CNT_ZERO);

  // Next-state selection for the burst controller
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (count_zero) begin
            next_state = S_DONE;
          end else if (mode) begin
            next_state = S_WR_WAIT;
          end else begin
            next_state = S_RD_ISSUE;
          end
        end else begin
          next_state = S_IDLE;
        end
      end
      S_RD_ISSUE: next_state = S_RD_SEND;
      S_RD_SEND: begin
        if (out_ready) begin
          next_state = last_word ? S_DONE : S_RD_ISSUE;
        end else begin
          next_state = S_RD_SEND;
        end
      end
      S_WR_WAIT: begin
        if (in_valid) begin
          next_state = S_WR_ISSUE;
        end else begin
          next_state = S_WR_WAIT;
        end
      end
      S_WR_ISSUE: next_state = last_word ? S_DONE : S_WR_WAIT;
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // State register and registered outputs; memory commands are set up one
  // cycle ahead so mem_wrrd is valid for exactly the issue-state cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_wrrd  <= WRRD_IDLE;
      mem_addr  <= ADDR_ZERO;
      mem_wdata <= DATA_ZERO;
      out_data  <= DATA_ZERO;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      cur_addr  <= ADDR_ZERO;
      remaining <= CNT_ZERO;
    end else begin
      state    <= next_state;
      mem_wrrd <= WRRD_IDLE;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            cur_addr  <= base_addr;
            remaining <= count;
            if (count_zero) begin
              done <= 1'b1;
            end else if (mode) begin
              in_ready <= 1'b1;
            end else begin
              mem_wrrd <= WRRD_READ;
              mem_addr <= base_addr;
            end
          end
        end
        S_RD_ISSUE: begin
          out_data  <= mem_rdata;
          out_valid <= 1'b1;
        end
        S_RD_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            remaining <= remaining - CNT_ONE;
            cur_addr  <= addr_next;
            if (last_word) begin
              done <= 1'b1;
            end else begin
              mem_wrrd <= WRRD_READ;
              mem_addr <= addr_next;
            end
          end
        end
        S_WR_WAIT: begin
          if (in_valid) begin
            mem_wdata <= in_data;
            in_ready  <= 1'b0;
            mem_wrrd  <= WRRD_WRITE;
            mem_addr  <= cur_addr;
          end
        end
        S_WR_ISSUE: begin
          remaining <= remaining - CNT_ONE;
          cur_addr  <= addr_next;
          if (last_word) begin
            done <= 1'b1;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_DONE: begin
          busy <= 1'b0;
        end
        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_streamer.sv
// Scoreboard bench for data_memory_streamer with a behavioural data memory
// (negedge-acting, mem[i]=i at start) and a reference copy of its contents.
module tb_data_memory_streamer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic [10:0] base_addr;
  logic [11:0] count;
  logic        busy;
  logic        done;
  logic [1:0]  mem_wrrd;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;

  data_memory_streamer dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .count(count), .busy(busy), .done(done), .mem_wrrd(mem_wrrd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );

  logic [15:0] mem     [0:2047];
  logic [15:0] ref_mem [0:2047];
  logic [15:0] exp_q [$];
  logic [10:0] rd_q [$];
  logic [26:0] wr_q [$];
  logic [15:0] ld_words [$];
  logic        cur_mode;
  int          checks = 0;
  int          passes = 0;
  int          n_reads = 0;
  int          n_writes = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = 16'(i);
      ref_mem[i] = 16'(i);
    end
  end

  // Behavioural data memory: acts on the falling edge
  always @(negedge clk) begin
    if (mem_wrrd == 2'b10) mem[mem_addr] <= mem_wdata;
    else if (mem_wrrd == 2'b01) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    checks++;
    $display("FAIL %s: event not matched by scoreboard or bound expired", nm);
  endtask

  // Monitor: pops expectations whenever the DUT issues a memory op or streams a word
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wrrd != 2'b00) chk("wrrd_legal", 32'(mem_wrrd == 2'b11), 32'd0);
      if (mem_wrrd == 2'b01) begin
        n_reads++;
        if (rd_q.size() == 0) fail_now("unexpected_read");
        else chk("read_addr", 32'(mem_addr), 32'(rd_q.pop_front()));
      end
      if (mem_wrrd == 2'b10) begin
        n_writes++;
        if (wr_q.size() == 0) fail_now("unexpected_write");
        else chk("write_addr_data", 32'({mem_addr, mem_wdata}), 32'(wr_q.pop_front()));
      end
      if (out_valid) begin
        chk("out_valid_mode", 32'(cur_mode), 32'd0);
        if (exp_q.size() == 0) fail_now("unexpected_out");
        else if (out_ready) chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        else chk("out_hold", 32'(out_data), 32'(exp_q[0]));
      end
      if (in_ready) chk("in_ready_mode", 32'(cur_mode), 32'd1);
    end
  end

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({nm, "_wrrd"}, 32'(mem_wrrd), 32'd0);
    chk({nm, "_addr"}, 32'(mem_addr), 32'd0);
    chk({nm, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({nm, "_out_data"}, 32'(out_data), 32'd0);
  endtask

  // One complete burst; lat = posedges from start sample to first done observation
  task automatic burst(input logic m, input logic [10:0] base, input logic [11:0] cnt,
                       input int stall, input bit rnd, input bit poke, output int lat);
    int idx;
    int sc;
    int c;
    bit pend;
    logic [10:0] a;
    cur_mode = m;
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + 11'(i);
      if (!m) begin
        exp_q.push_back(ref_mem[a]);
        rd_q.push_back(a);
      end else begin
        wr_q.push_back({a, ld_words[i]});
        ref_mem[a] = ld_words[i];
      end
    end
    @(posedge clk); #1;
    start = 1'b1; mode = m; base_addr = base; count = cnt;
    idx = 0; sc = 0; pend = 1'b0; c = 0; lat = -1;
    while (c < 3000) begin
      @(posedge clk); #1;
      c++;
      if (c == 1) begin
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
      end
      if (poke && c == 3) begin
        start = 1'b1; mode = ~m; base_addr = base + 11'd5; count = 12'd7;
      end else if (poke && c == 4) begin
        start = 1'b0;
      end
      if (pend) idx++;
      if (done) begin
        lat = c;
        break;
      end
      if (!m) begin
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        else if (out_valid) begin
          out_ready = (sc >= stall);
          sc++;
        end else begin
          sc = 0;
          out_ready = (stall == 0);
        end
      end else if (idx < int'(cnt)) begin
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = ld_words[idx];
      end else begin
        in_valid = 1'b0;
      end
      pend = in_valid && in_ready;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (lat < 0) begin
      fail_now("done_timeout");
    end else begin
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_low_after", 32'(busy), 32'd0);
    end
    chk("queues_drained", 32'(exp_q.size() + rd_q.size() + wr_q.size()), 32'd0);
    exp_q.delete(); rd_q.delete(); wr_q.delete();
  endtask

  initial begin
    int lat;
    int r0;
    int w0;
    int c;
    rst = 1'b1; start = 1'b0; mode = 1'b0; base_addr = 11'd0; count = 12'd0;
    out_ready = 1'b0; in_data = 16'd0; in_valid = 1'b0; cur_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // DUMP 0..3, always ready
    r0 = n_reads;
    burst(1'b0, 11'd0, 12'd4, 0, 1'b0, 1'b0, lat);
    chk("dump4_latency", 32'(lat), 32'd9);
    chk("dump4_reads", 32'(n_reads - r0), 32'd4);

    // DUMP with 5-cycle stalls per word
    r0 = n_reads;
    burst(1'b0, 11'd1, 12'd2, 5, 1'b0, 1'b0, lat);
    chk("stall_reads", 32'(n_reads - r0), 32'd2);

    // LOAD across the top-of-memory wrap, then read it back
    ld_words.delete();
    ld_words.push_back(16'hAAAA);
    ld_words.push_back(16'h5555);
    w0 = n_writes;
    burst(1'b1, 11'd2047, 12'd2, 0, 1'b0, 1'b0, lat);
    chk("load2_latency", 32'(lat), 32'd5);
    chk("load2_writes", 32'(n_writes - w0), 32'd2);
    burst(1'b0, 11'd2047, 12'd2, 0, 1'b0, 1'b0, lat);

    // count == 0 in both modes
    r0 = n_reads; w0 = n_writes;
    burst(1'b0, 11'd9, 12'd0, 0, 1'b0, 1'b0, lat);
    chk("zero_dump_latency", 32'(lat), 32'd1);
    burst(1'b1, 11'd9, 12'd0, 0, 1'b0, 1'b0, lat);
    chk("zero_load_latency", 32'(lat), 32'd1);
    chk("zero_no_memops", 32'((n_reads - r0) + (n_writes - w0)), 32'd0);

    // Reset after the first of three LOAD words
    cur_mode = 1'b1;
    wr_q.push_back({11'd100, 16'h1234});
    ref_mem[100] = 16'h1234;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1; base_addr = 11'd100; count = 12'd3;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
    c = 0;
    while (mem_wrrd != 2'b10 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    if (mem_wrrd != 2'b10) fail_now("rst_first_write");
    @(negedge clk); #1;
    in_data = 16'hBEEF;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("midburst_reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("no_ready_after_rst", 32'(in_ready), 32'd0);
      chk("no_memop_after_rst", 32'(mem_wrrd), 32'd0);
    end
    in_valid = 1'b0;
    chk("rst_writes_done", 32'(wr_q.size()), 32'd0);
    wr_q.delete();
    burst(1'b0, 11'd100, 12'd3, 0, 1'b0, 1'b0, lat);

    // start pulsed mid-burst must be ignored
    r0 = n_reads;
    burst(1'b0, 11'd10, 12'd3, 0, 1'b0, 1'b1, lat);
    chk("poke_latency", 32'(lat), 32'd7);
    chk("poke_reads", 32'(n_reads - r0), 32'd3);

    // Randomized bursts
    for (int k = 0; k < 12; k++) begin
      logic        rm;
      logic [10:0] rb;
      logic [11:0] rc;
      rm = 1'($urandom_range(0, 1));
      rb = 11'($urandom_range(0, 2047));
      rc = 12'($urandom_range(1, 6));
      if (k >= 8) rb = 11'(2045 + k - 8);
      ld_words.delete();
      for (int i = 0; i < int'(rc); i++) ld_words.push_back(16'($urandom));
      burst(rm, rb, rc, 0, 1'b1, 1'b0, lat);
      burst(1'b0, rb, rc, 0, 1'b1, 1'b0, lat);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
